// File: rtl/game_ctrl.sv
// Pinball game-flow controller: sequences RESET/WAIT/START/GET/OVER,
// scores each landing against the latched group and tracks remaining balls.
module game_ctrl #(
  parameter int BALLS      = 5,
  parameter int HIT_POINTS = 10,
  parameter int GET_HOLD   = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_down,
  input  logic       ball_landed,
  input  logic [2:0] landed_group,
  input  logic [2:0] selected_group,
  output logic [2:0] state,
  output logic [7:0] score,
  output logic [3:0] balls_left,
  output logic       hit
);

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_WAIT  = 3'd1,
    S_START = 3'd2,
    S_GET   = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam int              CNT_W      = (GET_HOLD > 1) ? $clog2(GET_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(GET_HOLD - 1);
  localparam logic [3:0]      BALLS_INIT = 4'(BALLS);
  localparam logic [7:0]      HIT_INC    = 8'(HIT_POINTS);

  state_t           st;
  logic [CNT_W-1:0] hold_cnt;
  logic             match;

  // Add with a 9-bit sum and clamp at the 8-bit ceiling.
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  assign state = st;
  assign match = (landed_group == selected_group);

  // Game-flow FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (reset) begin
      st         <= S_RESET;
      score      <= '0;
      balls_left <= BALLS_INIT;
      hit        <= 1'b0;
      hold_cnt   <= '0;
    end else begin
      case (st)
        S_RESET: begin
          st         <= S_WAIT;
          score      <= '0;
          balls_left <= BALLS_INIT;
          hit        <= 1'b0;
          hold_cnt   <= '0;
        end
        S_WAIT: begin
          if (btn_down) st <= S_START;
        end
        S_START: begin
          // A press coinciding with a landing is ignored; the landing wins.
          if (ball_landed) begin
            st       <= S_GET;
            hold_cnt <= '0;
            hit      <= match;
            if (balls_left != 4'd0) balls_left <= balls_left - 1'b1;
            if (match) score <= sat_add(score, HIT_INC);
          end
        end
        S_GET: begin
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt <= '0;
            st       <= (balls_left == 4'd0) ? S_OVER : S_WAIT;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        S_OVER: begin
          // score and hit stay frozen so the final result remains displayed.
          if (btn_down) st <= S_RESET;
        end
        default: st <= S_RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed scenarios with literal
// expectations plus randomized play checked against a behavioural model.
module tb_game_ctrl;

  localparam int BALLS      = 3;
  localparam int HIT_POINTS = 100;
  localparam int GET_HOLD   = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_down = 1'b0;
  logic       ball_landed = 1'b0;
  logic [2:0] landed_group = 3'd0;
  logic [2:0] selected_group = 3'd0;
  logic [2:0] state;
  logic [7:0] score;
  logic [3:0] balls_left;
  logic       hit;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Behavioural model state (plain integers, spec-level meaning).
  int m_state, m_score, m_balls, m_hit, m_hold;

  game_ctrl #(.BALLS(BALLS), .HIT_POINTS(HIT_POINTS), .GET_HOLD(GET_HOLD)) dut (
    .clk(clk), .reset(reset), .btn_down(btn_down), .ball_landed(ball_landed),
    .landed_group(landed_group), .selected_group(selected_group),
    .state(state), .score(score), .balls_left(balls_left), .hit(hit)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one edge's worth of inputs to the model, following the game rules.
  task automatic model_step(input bit rst, input bit btn, input bit land,
                            input int lg, input int sg);
    if (rst) begin
      m_state = 0; m_score = 0; m_balls = BALLS; m_hit = 0; m_hold = 0;
    end else begin
      case (m_state)
        0: begin m_state = 1; m_score = 0; m_balls = BALLS; m_hit = 0; m_hold = 0; end
        1: if (btn) m_state = 2;
        2: if (land) begin
             m_state = 3;
             m_hold  = 0;
             if (m_balls > 0) m_balls = m_balls - 1;
             m_hit = (lg == sg) ? 1 : 0;
             if (m_hit == 1) m_score = (m_score + HIT_POINTS > 255) ? 255 : m_score + HIT_POINTS;
           end
        3: begin
             m_hold = m_hold + 1;
             if (m_hold == GET_HOLD) begin
               m_hold  = 0;
               m_state = (m_balls == 0) ? 4 : 1;
             end
           end
        4: if (btn) m_state = 0;
        default: m_state = 0;
      endcase
    end
  endtask

  // One clock: drive inputs, step the model on the edge, settle past the edge.
  task automatic tick(input bit rst, input bit btn, input bit land,
                      input int lg, input int sg);
    @(negedge clk);
    #1;
    reset = rst; btn_down = btn; ball_landed = land;
    landed_group = 3'(lg); selected_group = 3'(sg);
    @(posedge clk);
    model_step(rst, btn, land, lg, sg);
    #1;
    reset = 1'b0; btn_down = 1'b0; ball_landed = 1'b0;
  endtask

  // Count GET cycles starting with the one just entered; returns total.
  task automatic count_get(output int n);
    n = 1;
    while (state == 3'd3 && n < 20) begin
      tick(0, 1, 1, 3, 3);
      if (state == 3'd3) n++;
    end
  endtask

  // Model-versus-DUT comparison on every cycle once the model is seeded.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_state", int'(state), m_state);
      check("model_score", int'(score), m_score);
      check("model_balls", int'(balls_left), m_balls);
      check("model_hit",   int'(hit), m_hit);
    end
  end

  initial begin
    int n;
    bit r, b, l;
    int lg, sg;

    // Reset held two cycles, then released.
    tick(1, 0, 0, 0, 0);
    cmp_en = 1'b1;
    tick(1, 0, 0, 0, 0);
    check("rst_state", int'(state), 0);
    check("rst_score", int'(score), 0);
    check("rst_balls", int'(balls_left), 3);
    check("rst_hit", int'(hit), 0);
    tick(0, 0, 0, 0, 0);
    check("entry_wait", int'(state), 1);

    // Matching shot.
    tick(0, 1, 0, 0, 3);
    check("press_start", int'(state), 2);
    tick(0, 0, 1, 3, 3);
    check("hit1_state", int'(state), 3);
    check("hit1_score", int'(score), 100);
    check("hit1_balls", int'(balls_left), 2);
    check("hit1_hit", int'(hit), 1);
    count_get(n);
    check("get_len1", n, 4);
    check("after_get1", int'(state), 1);
    check("get_ignore_score", int'(score), 100);

    // Miss with a simultaneous press.
    tick(0, 1, 0, 0, 3);
    tick(0, 1, 1, 5, 3);
    check("miss_state", int'(state), 3);
    check("miss_score", int'(score), 100);
    check("miss_hit", int'(hit), 0);
    check("miss_balls", int'(balls_left), 1);
    count_get(n);
    check("get_len2", n, 4);

    // Last ball, game over, ignored landing, restart.
    tick(0, 1, 0, 0, 6);
    tick(0, 0, 1, 6, 6);
    check("hit3_score", int'(score), 200);
    count_get(n);
    check("over_state", int'(state), 4);
    check("over_balls", int'(balls_left), 0);
    tick(0, 0, 1, 2, 2);
    check("over_ignore_land", int'(state), 4);
    check("over_hold_score", int'(score), 200);
    tick(0, 1, 0, 0, 0);
    check("restart_reset", int'(state), 0);
    tick(0, 0, 0, 0, 0);
    check("restart_wait", int'(state), 1);
    check("restart_score", int'(score), 0);
    check("restart_balls", int'(balls_left), 3);

    // Saturation across three matching shots: 100, 200, 255.
    for (int s = 0; s < 2; s++) begin
      tick(0, 1, 0, 0, 1);
      tick(0, 0, 1, 1, 1);
      count_get(n);
    end
    check("sat_pre", int'(score), 200);
    tick(0, 1, 0, 0, 1);
    tick(0, 0, 1, 1, 1);
    check("sat_score", int'(score), 255);

    // Reset on the second GET cycle.
    tick(0, 0, 0, 0, 0);
    check("get2_state", int'(state), 3);
    tick(1, 0, 0, 0, 0);
    check("midget_state", int'(state), 0);
    check("midget_score", int'(score), 0);
    check("midget_balls", int'(balls_left), 3);
    tick(0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 2);
    tick(0, 0, 1, 4, 2);
    count_get(n);
    check("get_len_after_rst", n, 4);

    // Randomized play against the model.
    for (int c = 0; c < 3000; c++) begin
      r  = ($urandom_range(0, 199) == 0);
      b  = ($urandom_range(0, 3) == 0);
      l  = ($urandom_range(0, 2) == 0);
      sg = $urandom_range(0, 7);
      lg = ($urandom_range(0, 1) == 0) ? sg : $urandom_range(0, 7);
      tick(r, b, l, lg, sg);
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Top-level pinball game-flow controller. Consumes one-pulse button presses and ball-landing events, sequences the game through RESET/WAIT/START/GET/OVER, and drives the 3-bit `state` bus that the group-select stage decodes to flash, latch and hold the player's chosen group. Compares each landing against the latched `selected_group` fed back from group select, keeps score and remaining balls, and provides the counts for display.

## Interface
Parameters:
- `BALLS`, 5: balls per game, 1..15.
- `HIT_POINTS`, 10: score added per matching landing, 1..255.
- `GET_HOLD`, 50_000_000: cycles spent in GET before leaving it, ≥1.

Ports:
- `clk` in 1: single system clock; every register is clocked on its rising edge.
- `reset` in 1: synchronous reset, active-high.
- `btn_down` in 1: debounced one-cycle press pulse.
- `ball_landed` in 1: one-cycle pulse when the ball settles in a group.
- `landed_group` in 3: group index, valid only while `ball_landed`=1.
- `selected_group` in 3: latched group from group select.
- `state` out 3: RESET=0, WAIT=1, START=2, GET=3, OVER=4.
- `score` out 8: accumulated score, saturating.
- `balls_left` out 4: balls not yet played.
- `hit` out 1: result of the most recent landing, 1=matched.

## Operation
- Registered Moore FSM. All outputs are registers; no combinational input-to-output path.
- Reset values, applied at the first edge with `reset`=1 and irrespective of current state: `state`=RESET, `score`=0, `balls_left`=BALLS, `hit`=0, hold counter=0.
- RESET: unconditionally → WAIT on the next edge. Reloads `score`=0, `balls_left`=BALLS, `hit`=0.
- WAIT: `btn_down` → START. All other inputs ignored.
- START:
  - `ball_landed` → GET. In the same edge:
    - `balls_left` decrements by 1.
    - `hit` is set to (`landed_group` == `selected_group`).
    - On a match, `score` = min(`score` + HIT_POINTS, 255). Compute with a 9-bit sum, then clamp.
  - `btn_down` is ignored. If it coincides with `ball_landed`, the landing is processed normally.
- GET: the hold counter counts from 0. At count GET_HOLD−1 the counter clears, and the FSM goes to OVER if `balls_left`==0, else to WAIT. Both inputs are ignored.
- OVER: `btn_down` → RESET. `score` and `hit` hold so the final result stays on display.
- Encodings 5–7 are never produced. If reached, the next state is RESET.
- `hit` holds its value until the next landing or until RESET.
- `balls_left` never decrements below 0. START is reachable only when `balls_left` ≥ 1.

## Timing
- `btn_down` high before edge k in WAIT: `state`=START immediately after edge k. Group select captures its value on the same edge, so `selected_group` is stable throughout START.
- `ball_landed` before edge k in START: after edge k, `state`=GET and `score`, `balls_left` and `hit` are all updated together.
- The first GET cycle follows edge k. GET lasts exactly GET_HOLD cycles, then exits.
- RESET state lasts exactly 1 cycle. A full new game, from the OVER press to WAIT, takes 2 edges.
- `reset` asserted mid-GET or mid-START: next edge gives the reset values, and any pending landing is discarded.

## Test plan
- Reset/entry: assert `reset` 2 cycles, then release. Required: `state`=0 during reset, `state`=1 one cycle after release, `score`=0, `balls_left`=5, `hit`=0.
- Matching shot, with GET_HOLD=4 and `selected_group`=3: press → START; `ball_landed` with `landed_group`=3. Required: `state`=3, `score`=10, `balls_left`=4, `hit`=1; exactly 4 cycles in GET, then `state`=1.
- Miss plus simultaneity: in START, `landed_group`=5 with `selected_group`=3, asserted together with `btn_down`. Required: GET, `score` unchanged, `hit`=0, `balls_left` decremented. In GET, `btn_down` and `ball_landed` pulses cause no change.
- Game over and restart, with BALLS=2: two landings. Required: after the 2nd GET, `state`=4 and `balls_left`=0. Further `ball_landed` is ignored. `btn_down` → `state`=0 → `state`=1, `score`=0, `balls_left`=2.
- Saturation, with HIT_POINTS=200 and BALLS=3: two matching shots. Required: `score`=200, then 255 (not 144).
- Reset mid-GET: assert `reset` on the 2nd GET cycle. Required: next cycle `state`=0, `score`=0, `balls_left`=BALLS, hold counter restarts from 0 on the next GET.
